// File: rtl/instr_mem_if_pkg.sv
// rtl/instr_mem_if_pkg.sv - shared constants and types for the instruction-memory interface
package instr_mem_if_pkg;

    localparam int IMEM_ADDR_WIDTH      = 32;
    localparam int IMEM_DATA_WIDTH      = 32;
    localparam int IMEM_MAX_OUTSTANDING = 2;
    localparam int IMEM_BUF_DEPTH       = 2;

    typedef struct packed {
        logic [IMEM_ADDR_WIDTH-1:0] addr;
        logic                       kill;
    } imem_pending_t;

    typedef struct packed {
        logic [IMEM_ADDR_WIDTH-1:0] addr;
        logic [IMEM_DATA_WIDTH-1:0] data;
    } imem_resp_t;

    function automatic logic [IMEM_ADDR_WIDTH-1:0] word_align(input logic [IMEM_ADDR_WIDTH-1:0] a);
        return {a[IMEM_ADDR_WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_mem_if_if.sv
// rtl/instr_mem_if_if.sv - fetch, memory and decode handshake bundle
interface instr_mem_if_if;
    import instr_mem_if_pkg::*;

    logic                       fetch_req_ip;
    logic [IMEM_ADDR_WIDTH-1:0] fetch_addr_ip;
    logic                       fetch_gnt_op;
    logic                       flush_ip;
    logic                       mem_req_op;
    logic [IMEM_ADDR_WIDTH-1:0] mem_addr_op;
    logic                       mem_gnt_ip;
    logic                       mem_rvalid_ip;
    logic [IMEM_DATA_WIDTH-1:0] mem_rdata_ip;
    logic                       instr_valid_op;
    logic [IMEM_DATA_WIDTH-1:0] instr_data_op;
    logic [IMEM_ADDR_WIDTH-1:0] instr_pc_addr_op;
    logic                       instr_ready_ip;

    modport slave (
        input  fetch_req_ip, fetch_addr_ip, flush_ip, mem_gnt_ip, mem_rvalid_ip,
        input  mem_rdata_ip, instr_ready_ip,
        output fetch_gnt_op, mem_req_op, mem_addr_op, instr_valid_op, instr_data_op,
        output instr_pc_addr_op
    );

    modport master (
        output fetch_req_ip, fetch_addr_ip, flush_ip, mem_gnt_ip, mem_rvalid_ip,
        output mem_rdata_ip, instr_ready_ip,
        input  fetch_gnt_op, mem_req_op, mem_addr_op, instr_valid_op, instr_data_op,
        input  instr_pc_addr_op
    );

endinterface

// File: rtl/instr_mem_if_sync_fifo.sv
// rtl/instr_mem_if_sync_fifo.sv - power-of-two FIFO with wrap-bit pointers and a clear input
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [$clog2(DEPTH)-1:0]   rd_idx,
    output logic [$clog2(DEPTH)-1:0]   wr_idx
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign rd_idx   = rd_ptr_q[AW-1:0];
    assign wr_idx   = wr_ptr_q[AW-1:0];
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);
    assign count    = wr_ptr_q - rd_ptr_q;
    assign pop_data = mem_q[rd_idx];

    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        // clear wins over any push/pop in the same cycle
        if (clear) begin
            rd_ptr_d = wr_ptr_q;
        end else begin
            if (do_push) begin
                mem_d[wr_idx] = push_data;
                wr_ptr_d      = wr_ptr_q + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/instr_mem_if.sv
// rtl/instr_mem_if.sv - in-order instruction fetch bridge with credit, flush and kill handling
module instr_mem_if
    import instr_mem_if_pkg::*;
#(
    parameter int MAX_OUTSTANDING = IMEM_MAX_OUTSTANDING,
    parameter int BUF_DEPTH       = IMEM_BUF_DEPTH
) (
    input  logic           clock,
    input  logic           reset,
    instr_mem_if_if.slave  bus
);

    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam int RW = $clog2(BUF_DEPTH);

    imem_pending_t        pend_push_data, pend_head;
    imem_resp_t           resp_push_data, resp_head;
    logic                 pend_push, pend_pop, pend_full, pend_empty;
    logic                 resp_push, resp_pop, resp_full, resp_empty;
    logic [PW:0]          pend_count;
    logic [RW:0]          resp_count;
    logic [PW-1:0]        pend_rd_idx, pend_wr_idx;
    logic [RW-1:0]        resp_rd_idx_unused, resp_wr_idx_unused;
    logic [MAX_OUTSTANDING-1:0] kill_q, kill_d;
    logic [31:0]          in_flight;
    logic                 credit, mem_req, head_killed;

    always_comb begin
        resp_pop  = !resp_empty && bus.instr_ready_ip && !bus.flush_ip;
        pend_pop  = bus.mem_rvalid_ip && !pend_empty;
        // a decode pop this cycle frees a slot, which keeps streaming at one word per cycle
        in_flight = 32'(pend_count) + 32'(resp_count) - 32'(resp_pop);
        credit    = (in_flight < 32'(BUF_DEPTH)) &&
                    ((32'(pend_count) - 32'(pend_pop)) < 32'(MAX_OUTSTANDING));
        mem_req   = !reset && bus.fetch_req_ip && credit && !bus.flush_ip;
        pend_push = mem_req && bus.mem_gnt_ip;

        head_killed = kill_q[pend_rd_idx] || pend_head.kill;
        resp_push   = pend_pop && !head_killed && !bus.flush_ip;

        pend_push_data = '{addr: word_align(bus.fetch_addr_ip), kill: 1'b0};
        resp_push_data = '{addr: pend_head.addr, data: bus.mem_rdata_ip};

        // kill every slot on flush; a fresh push re-arms its own slot
        kill_d = kill_q;
        if (bus.flush_ip) begin
            kill_d = '1;
        end else if (pend_push) begin
            kill_d[pend_wr_idx] = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            kill_q <= '0;
        end else begin
            kill_q <= kill_d;
        end
    end

    sync_fifo #(
        .WIDTH ($bits(imem_pending_t)),
        .DEPTH (MAX_OUTSTANDING)
    ) u_pend_fifo (
        .clock     (clock),
        .reset     (reset),
        .clear     (1'b0),
        .push      (pend_push),
        .push_data (pend_push_data),
        .pop       (pend_pop),
        .pop_data  (pend_head),
        .full      (pend_full),
        .empty     (pend_empty),
        .count     (pend_count),
        .rd_idx    (pend_rd_idx),
        .wr_idx    (pend_wr_idx)
    );

    sync_fifo #(
        .WIDTH ($bits(imem_resp_t)),
        .DEPTH (BUF_DEPTH)
    ) u_resp_fifo (
        .clock     (clock),
        .reset     (reset),
        .clear     (bus.flush_ip),
        .push      (resp_push),
        .push_data (resp_push_data),
        .pop       (resp_pop),
        .pop_data  (resp_head),
        .full      (resp_full),
        .empty     (resp_empty),
        .count     (resp_count),
        .rd_idx    (resp_rd_idx_unused),
        .wr_idx    (resp_wr_idx_unused)
    );

    assign bus.mem_req_op       = mem_req;
    assign bus.mem_addr_op      = reset ? '0 : word_align(bus.fetch_addr_ip);
    assign bus.fetch_gnt_op     = pend_push;
    assign bus.instr_valid_op   = !resp_empty;
    assign bus.instr_data_op    = resp_empty ? '0 : resp_head.data;
    assign bus.instr_pc_addr_op = resp_empty ? '0 : resp_head.addr;

    a_resp_no_overflow: assert property (@(posedge clock) disable iff (reset)
        !(resp_push && resp_full && !resp_pop));
    a_pend_no_overflow: assert property (@(posedge clock) disable iff (reset)
        !(pend_push && pend_full && !pend_pop));

endmodule

// File: tb/tb_instr_mem_if.sv
// tb/tb_instr_mem_if.sv - scoreboard bench for instr_mem_if
module tb_instr_mem_if;
    import instr_mem_if_pkg::*;

    logic clock;
    logic reset;

    instr_mem_if_if bus();

    instr_mem_if dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem_q[$];
    logic [31:0] rsp_addr;
    bit          mem_en;
    bit          inject;
    int          checks;
    int          errors;
    int          cyc;

    always @(posedge clock) cyc <= cyc + 1;

    // memory model: remembers granted addresses, answers in order one cycle later
    always @(negedge clock) begin
        if (!reset && bus.fetch_gnt_op) mem_q.push_back(bus.mem_addr_op);
    end

    always @(posedge clock) begin
        #2;
        if (reset) begin
            mem_q.delete();
            bus.mem_rvalid_ip = 1'b0;
            bus.mem_rdata_ip  = '0;
        end else if (mem_en && mem_q.size() > 0) begin
            rsp_addr          = mem_q.pop_front();
            bus.mem_rvalid_ip = 1'b1;
            bus.mem_rdata_ip  = {16'hC0DE, rsp_addr[15:0]};
        end else if (inject) begin
            bus.mem_rvalid_ip = 1'b1;
            bus.mem_rdata_ip  = 32'hDEADBEEF;
        end else begin
            bus.mem_rvalid_ip = 1'b0;
            bus.mem_rdata_ip  = '0;
        end
    end

    // scoreboard monitor
    always @(negedge clock) begin
        exp_t e;
        if (!reset && bus.instr_valid_op && bus.instr_ready_ip) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_instr got pc %h data %h, required nothing", bus.instr_pc_addr_op, bus.instr_data_op);
            end else begin
                e = exp_q.pop_front();
                if (bus.instr_pc_addr_op !== e.pc || bus.instr_data_op !== e.data ||
                    (e.cyc >= 0 && cyc != e.cyc)) begin
                    errors++;
                    $display("FAIL instr_out got pc %h data %h cyc %0d, required pc %h data %h cyc %0d",
                             bus.instr_pc_addr_op, bus.instr_data_op, cyc, e.pc, e.data, e.cyc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h required %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clock);
    endtask

    task automatic expect_instr(input logic [31:0] pc, input logic [31:0] data, input int c);
        exp_t e;
        e.pc   = pc;
        e.data = data;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) at_neg();
        chk(name, 32'(exp_q.size()), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        reset              = 1'b1;
        bus.fetch_req_ip   = 1'b0;
        bus.fetch_addr_ip  = '0;
        bus.flush_ip       = 1'b0;
        bus.mem_gnt_ip     = 1'b1;
        bus.instr_ready_ip = 1'b1;
        mem_en             = 1'b1;
        inject             = 1'b0;
        checks             = 0;
        errors             = 0;
        repeat (2) step();

        // reset mid-stream
        reset              = 1'b0;
        bus.instr_ready_ip = 1'b0;
        bus.fetch_req_ip   = 1'b1;
        bus.fetch_addr_ip  = 32'h100;
        repeat (4) step();
        at_neg();
        chk("t1_valid_before_reset", 32'(bus.instr_valid_op), 1);
        step();
        reset = 1'b1;
        #1;
        chk("t1_rst_mem_req",   32'(bus.mem_req_op), 0);
        chk("t1_rst_mem_addr",  bus.mem_addr_op, 0);
        chk("t1_rst_fetch_gnt", 32'(bus.fetch_gnt_op), 0);
        chk("t1_rst_valid",     32'(bus.instr_valid_op), 0);
        chk("t1_rst_data",      bus.instr_data_op, 0);
        chk("t1_rst_pc",        bus.instr_pc_addr_op, 0);

        // streaming 0x0, 0x4, 0x8 right after release
        step();
        reset              = 1'b0;
        bus.instr_ready_ip = 1'b1;
        bus.fetch_addr_ip  = 32'h0;
        at_neg();
        chk("t2_gnt_0x0", 32'(bus.fetch_gnt_op), 1);
        expect_instr(32'h0, 32'hC0DE0000, cyc + 2);
        step();
        bus.fetch_addr_ip = 32'h4;
        at_neg();
        chk("t2_gnt_0x4", 32'(bus.fetch_gnt_op), 1);
        expect_instr(32'h4, 32'hC0DE0004, cyc + 2);
        step();
        bus.fetch_addr_ip = 32'h8;
        at_neg();
        chk("t2_gnt_0x8", 32'(bus.fetch_gnt_op), 1);
        expect_instr(32'h8, 32'hC0DE0008, cyc + 2);
        step();
        bus.fetch_req_ip = 1'b0;
        drain("t2_drain");

        // backpressure
        step();
        bus.instr_ready_ip = 1'b0;
        bus.fetch_req_ip   = 1'b1;
        bus.fetch_addr_ip  = 32'h200;
        at_neg();
        chk("t3_gnt_200", 32'(bus.fetch_gnt_op), 1);
        expect_instr(32'h200, 32'hC0DE0200, -1);
        step();
        bus.fetch_addr_ip = 32'h204;
        at_neg();
        chk("t3_gnt_204", 32'(bus.fetch_gnt_op), 1);
        expect_instr(32'h204, 32'hC0DE0204, -1);
        step();
        bus.fetch_addr_ip = 32'h208;
        at_neg();
        chk("t3_stall_a", 32'(bus.fetch_gnt_op), 0);
        step();
        at_neg();
        chk("t3_stall_b", 32'(bus.fetch_gnt_op), 0);
        chk("t3_valid_held", 32'(bus.instr_valid_op), 1);
        step();
        bus.instr_ready_ip = 1'b1;
        at_neg();
        chk("t3_gnt_208", 32'(bus.fetch_gnt_op), 1);
        expect_instr(32'h208, 32'hC0DE0208, -1);
        step();
        bus.fetch_addr_ip = 32'h20C;
        at_neg();
        chk("t3_gnt_20c", 32'(bus.fetch_gnt_op), 1);
        expect_instr(32'h20C, 32'hC0DE020C, -1);
        step();
        bus.fetch_req_ip = 1'b0;
        drain("t3_drain");

        // grant withheld for three cycles, unaligned PC
        step();
        bus.mem_gnt_ip    = 1'b0;
        bus.fetch_req_ip  = 1'b1;
        bus.fetch_addr_ip = 32'h23;
        for (int i = 0; i < 3; i++) begin
            at_neg();
            chk("t4_req_held",  32'(bus.mem_req_op), 1);
            chk("t4_addr_held", bus.mem_addr_op, 32'h20);
            chk("t4_no_gnt",    32'(bus.fetch_gnt_op), 0);
            step();
        end
        bus.mem_gnt_ip = 1'b1;
        at_neg();
        chk("t4_gnt", 32'(bus.fetch_gnt_op), 1);
        expect_instr(32'h20, 32'hC0DE0020, cyc + 2);
        step();
        bus.fetch_req_ip = 1'b0;
        drain("t4_drain");

        // flush with two requests in flight
        step();
        mem_en            = 1'b0;
        bus.fetch_req_ip  = 1'b1;
        bus.fetch_addr_ip = 32'h10;
        at_neg();
        chk("t5_gnt_10", 32'(bus.fetch_gnt_op), 1);
        step();
        bus.fetch_addr_ip = 32'h14;
        at_neg();
        chk("t5_gnt_14", 32'(bus.fetch_gnt_op), 1);
        step();
        bus.fetch_addr_ip = 32'h40;
        bus.flush_ip      = 1'b1;
        at_neg();
        chk("t5_flush_no_req", 32'(bus.mem_req_op), 0);
        step();
        bus.flush_ip = 1'b0;
        mem_en       = 1'b1;
        for (int i = 0; i < 10; i++) begin
            at_neg();
            if (bus.fetch_gnt_op) break;
            step();
        end
        chk("t5_gnt_40", 32'(bus.fetch_gnt_op), 1);
        expect_instr(32'h40, 32'hC0DE0040, -1);
        step();
        bus.fetch_req_ip = 1'b0;
        drain("t5_drain");

        // flush coincident with rvalid, then a spurious rvalid
        step();
        bus.instr_ready_ip = 1'b0;
        bus.fetch_req_ip   = 1'b1;
        bus.fetch_addr_ip  = 32'h60;
        at_neg();
        chk("t6_gnt_60", 32'(bus.fetch_gnt_op), 1);
        step();
        bus.fetch_addr_ip = 32'h64;
        at_neg();
        chk("t6_gnt_64", 32'(bus.fetch_gnt_op), 1);
        step();
        bus.fetch_req_ip = 1'b0;
        mem_en           = 1'b0;
        at_neg();
        chk("t6_buffered", 32'(bus.instr_valid_op), 1);
        chk("t6_head_pc",  bus.instr_pc_addr_op, 32'h60);
        step();
        bus.flush_ip = 1'b1;
        mem_en       = 1'b1;
        step();
        bus.flush_ip = 1'b0;
        mem_en       = 1'b0;
        inject       = 1'b1;
        at_neg();
        chk("t6_valid_after_flush", 32'(bus.instr_valid_op), 0);
        step();
        inject = 1'b0;
        at_neg();
        chk("t6_valid_after_spurious", 32'(bus.instr_valid_op), 0);
        step();
        bus.flush_ip       = 1'b1;
        bus.fetch_req_ip   = 1'b1;
        bus.fetch_addr_ip  = 32'h70;
        bus.instr_ready_ip = 1'b1;
        mem_en             = 1'b1;
        at_neg();
        chk("t6_idle_flush_no_req", 32'(bus.mem_req_op), 0);
        chk("t6_idle_flush_no_gnt", 32'(bus.fetch_gnt_op), 0);
        step();
        bus.flush_ip = 1'b0;
        at_neg();
        chk("t6_gnt_70", 32'(bus.fetch_gnt_op), 1);
        expect_instr(32'h70, 32'hC0DE0070, cyc + 2);
        step();
        bus.fetch_req_ip = 1'b0;
        drain("t6_drain");

        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
